div_share_ctrl: RTL and testbench

//   Sequencing controller/arbiter sharing one combinational 16-bit divider (devision_comb) between two requesters.

---
 rtl/div_share_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_div_share_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares one external combinational divider between two requesters.
//   Grants are round-robin, taken only while idle. The operands are
//   held on div_a/div_b for SETTLE_CYCLES cycles. After that the
//   divider outputs are captured into the owning port's response
//   registers. A zero divisor is answered at once without using the
//   divider. disp_value keeps the last quotient that was not an error.
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   req0_valid/ready/a/b           port0 request handshake and operands
//   req1_valid/ready/a/b           port1 request handshake and operands
//   resp0_valid/ready/y/rem/err    port0 response, held until accepted
//   resp1_valid/ready/y/rem/err    port1 response, held until accepted
//   div_a, div_b                   registered operands to the divider
//   div_y, div_rem                 quotient / remainder from the divider
//   disp_value                     last non-error quotient (to led_encoder)
//   busy                           controller is not idle
module div_share_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_y,
  output logic [WIDTH-1:0] resp0_rem,
  output logic             resp0_err,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_y,
  output logic [WIDTH-1:0] resp1_rem,
  output logic             resp1_err,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_y,
  input  logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] disp_value,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE_CYCLES);
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic             owner_r;        // port owning the current operation
  logic             last_r;         // port granted most recently
  logic             grant_valid_s;
  logic             grant_sel_s;    // 0 = port0, 1 = port1
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic             div_zero_s;

  // Round-robin grant, evaluated only while idle
  always_comb begin
    grant_valid_s = 1'b0;
    grant_sel_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid_s = 1'b1;
        grant_sel_s   = ~last_r;
      end else if (req0_valid) begin
        grant_valid_s = 1'b1;
        grant_sel_s   = 1'b0;
      end else if (req1_valid) begin
        grant_valid_s = 1'b1;
        grant_sel_s   = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_sel_s   = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_sel_s   = 1'b0;
    end
  end

  // Operand mux for the granted port
  always_comb begin
    sel_a_s = req0_a;
    sel_b_s = req0_b;
    if (grant_sel_s) begin
      sel_a_s = req1_a;
      sel_b_s = req1_b;
    end else begin
      sel_a_s = req0_a;
      sel_b_s = req0_b;
    end
  end

  assign div_zero_s = (sel_b_s == ZERO);
  assign req0_ready = grant_valid_s & ~grant_sel_s;
  assign req1_ready = grant_valid_s & grant_sel_s;
  assign busy       = (state_r != ST_IDLE);

  // Sequencing FSM, operand/response registers and display value
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      owner_r     <= 1'b0;
      last_r      <= 1'b1;          // port0 wins the first tie
      div_a       <= ZERO;
      div_b       <= ZERO;
      disp_value  <= ZERO;
      resp0_valid <= 1'b0;
      resp0_y     <= ZERO;
      resp0_rem   <= ZERO;
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_y     <= ZERO;
      resp1_rem   <= ZERO;
      resp1_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_valid_s) begin
            owner_r <= grant_sel_s;
            last_r  <= grant_sel_s;
            if (div_zero_s) begin
              // Answer immediately; divider operands stay as they were
              if (grant_sel_s) begin
                resp1_valid <= 1'b1;
                resp1_y     <= ONES;
                resp1_rem   <= sel_a_s;
                resp1_err   <= 1'b1;
              end else begin
                resp0_valid <= 1'b1;
                resp0_y     <= ONES;
                resp0_rem   <= sel_a_s;
                resp0_err   <= 1'b1;
              end
              state_r <= ST_RESP;
            end else begin
              div_a   <= sel_a_s;
              div_b   <= sel_b_s;
              cnt_r   <= CNT_ONE;   // first settle cycle is the next one
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_r == CNT_LAST) begin
            if (owner_r) begin
              resp1_valid <= 1'b1;
              resp1_y     <= div_y;
              resp1_rem   <= div_rem;
              resp1_err   <= 1'b0;
            end else begin
              resp0_valid <= 1'b1;
              resp0_y     <= div_y;
              resp0_rem   <= div_rem;
              resp0_err   <= 1'b0;
            end
            disp_value <= div_y;
            state_r    <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_RESP: begin
          if (owner_r) begin
            if (resp1_valid && resp1_ready) begin
              resp1_valid <= 1'b0;
              resp1_y     <= ZERO;
              resp1_rem   <= ZERO;
              resp1_err   <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end else begin
            if (resp0_valid && resp0_ready) begin
              resp0_valid <= 1'b0;
              resp0_y     <= ZERO;
              resp0_rem   <= ZERO;
              resp0_err   <= 1'b0;
              state_r     <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider model.
module tb_div_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = 16'd0, req0_b = 16'd0, req1_a = 16'd0, req1_b = 16'd0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [15:0] resp0_y, resp0_rem, resp1_y, resp1_rem;
  logic        resp0_err, resp1_err;
  logic [15:0] div_a, div_b, div_y, div_rem, disp_value;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // External combinational divider
  assign div_y   = (div_b != 16'd0) ? div_a / div_b : 16'hFFFF;
  assign div_rem = (div_b != 16'd0) ? div_a % div_b : div_a;

  div_share_ctrl #(.WIDTH(16), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y),
    .resp0_rem(resp0_rem), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y),
    .resp1_rem(resp1_rem), .resp1_err(resp1_err),
    .div_a(div_a), .div_b(div_b), .div_y(div_y), .div_rem(div_rem),
    .disp_value(disp_value), .busy(busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request and returns latency (negedges after the accept edge
  // until resp valid) and the observed response; then acknowledges it.
  task automatic run_op(input bit port, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [15:0] y, output logic [15:0] rem,
                        output logic err, output bit cleared);
    int n;
    @(negedge clk);
    if (port) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!(port ? resp1_valid : resp0_valid) && lat < 20) begin
      @(negedge clk); lat++;
    end
    y   = port ? resp1_y   : resp0_y;
    rem = port ? resp1_rem : resp0_rem;
    err = port ? resp1_err : resp0_err;
    if (port) resp1_ready = 1'b1; else resp0_ready = 1'b1;
    @(negedge clk);
    cleared = port ? (!resp1_valid && resp1_y == 16'd0 && resp1_rem == 16'd0 && !resp1_err)
                   : (!resp0_valid && resp0_y == 16'd0 && resp0_rem == 16'd0 && !resp0_err);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b%b required 00", resp1_valid, resp0_valid); end
    checks++; if (div_a !== 16'd0 || div_b !== 16'd0) begin errors++;
      $display("FAIL reset_div: got %0d/%0d required 0/0", div_a, div_b); end
    checks++; if (disp_value !== 16'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_disp_busy: got %0d,%b required 0,0", disp_value, busy); end
    checks++; if ({resp0_y, resp0_rem, resp1_y, resp1_rem} !== 64'd0 || resp0_err !== 1'b0 || resp1_err !== 1'b0) begin errors++;
      $display("FAIL reset_resp: response registers not zero"); end
  endtask

  task automatic test_basic();
    int lat; logic [15:0] y, rem; logic err; bit clr;
    run_op(1'b0, 16'd100, 16'd3, lat, y, rem, err, clr);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d required 3", lat); end
    checks++; if (y !== 16'd33 || rem !== 16'd1 || err !== 1'b0) begin errors++;
      $display("FAIL basic_result: got y=%0d rem=%0d err=%b required 33/1/0", y, rem, err); end
    checks++; if (disp_value !== 16'd33) begin errors++; $display("FAIL basic_disp: got %0d required 33", disp_value); end
    checks++; if (!clr || busy !== 1'b0) begin errors++; $display("FAIL basic_clear: cleared=%b busy=%b required 1,0", clr, busy); end
  endtask

  task automatic test_arbitration();
    int lat;
    pulse_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'd50;  req0_b = 16'd7;
    req1_valid = 1'b1; req1_a = 16'd200; req1_b = 16'd15;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++;
      $display("FAIL arb_first_grant: got %b%b required 01", req1_ready, req0_ready); end
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL arb_busy_block: ready1=%b busy=%b required 0,1", req1_ready, busy); end
    lat = 1;
    while (!resp0_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 3 || resp0_y !== 16'd7 || resp0_rem !== 16'd1) begin errors++;
      $display("FAIL arb_p0_result: lat=%0d y=%0d rem=%0d required 3/7/1", lat, resp0_y, resp0_rem); end
    resp0_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL arb_second_grant: got %b required 1", req1_ready); end
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    lat = 1;
    while (!resp1_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 3 || resp1_y !== 16'd13 || resp1_rem !== 16'd5 || resp1_err !== 1'b0) begin errors++;
      $display("FAIL arb_p1_result: lat=%0d y=%0d rem=%0d required 3/13/5", lat, resp1_y, resp1_rem); end
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat; logic [15:0] y, rem; logic err; bit clr;
    run_op(1'b1, 16'd1234, 16'd0, lat, y, rem, err, clr);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d required 1", lat); end
    checks++; if (y !== 16'hFFFF || rem !== 16'd1234 || err !== 1'b1) begin errors++;
      $display("FAIL dz_result: got y=%h rem=%0d err=%b required ffff/1234/1", y, rem, err); end
    checks++; if (disp_value !== 16'd13 || div_a !== 16'd200 || div_b !== 16'd15) begin errors++;
      $display("FAIL dz_untouched: disp=%0d div=%0d/%0d required 13, 200/15", disp_value, div_a, div_b); end
    checks++; if (!clr) begin errors++; $display("FAIL dz_clear: got 0 required 1"); end
  endtask

  task automatic test_backpressure();
    int lat; bit stable;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'd65535; req0_b = 16'd255;
    @(posedge clk); @(negedge clk);
    req0_a = 16'd9; req0_b = 16'd2;              // keep both requesting while held
    req1_valid = 1'b1; req1_a = 16'd8; req1_b = 16'd3;
    lat = 1;
    while (!resp0_valid && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency: got %0d required 3", lat); end
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (resp0_valid !== 1'b1 || resp0_y !== 16'd257 || resp0_rem !== 16'd0 || resp0_err !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++; if (!stable) begin errors++;
      $display("FAIL bp_hold: y=%0d rem=%0d valid=%b ready=%b%b required 257/0/1/00",
               resp0_y, resp0_rem, resp0_valid, req1_ready, req0_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    checks++; if (resp0_valid !== 1'b0 || resp0_y !== 16'd0 || resp0_rem !== 16'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_clear: valid=%b y=%0d busy=%b required 0/0/0", resp0_valid, resp0_y, busy); end
    checks++; if (disp_value !== 16'd257) begin errors++; $display("FAIL bp_disp: got %0d required 257", disp_value); end
  endtask

  task automatic test_reset_abort();
    bit quiet;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'd1000; req0_b = 16'd10;
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    checks++; if (busy !== 1'b1 || div_a !== 16'd1000) begin errors++;
      $display("FAIL abort_pre: busy=%b div_a=%0d required 1/1000", busy, div_a); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || div_a !== 16'd0 || div_b !== 16'd0 || disp_value !== 16'd0 || resp0_valid !== 1'b0) begin errors++;
      $display("FAIL abort_state: busy=%b div=%0d/%0d disp=%0d valid=%b required all 0",
               busy, div_a, div_b, disp_value, resp0_valid); end
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL abort_no_resp: got activity required none"); end
  endtask

  task automatic test_round_robin();
    logic [15:0] a0[3], b0[3], a1[3], b1[3];
    logic [15:0] ea, eb, gy, gr;
    int i0, i1, lat;
    bit got, exp_port;
    for (int i = 0; i < 3; i++) begin
      a0[i] = 16'($urandom); b0[i] = 16'($urandom_range(1, 65535));
      a1[i] = 16'($urandom); b1[i] = 16'($urandom_range(1, 300));
    end
    i0 = 0; i1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      req0_valid = (i0 < 3); if (i0 < 3) begin req0_a = a0[i0]; req0_b = b0[i0]; end
      req1_valid = (i1 < 3); if (i1 < 3) begin req1_a = a1[i1]; req1_b = b1[i1]; end
      #1;
      exp_port = (k % 2 == 1);
      checks++; if ({req1_ready, req0_ready} !== (exp_port ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rr_grant_%0d: got %b%b required port%0d", k, req1_ready, req0_ready, exp_port); end
      got = req1_ready;
      ea = got ? a1[i1] : a0[i0];
      eb = got ? b1[i1] : b0[i0];
      @(posedge clk); @(negedge clk);
      if (got) begin i1++; if (i1 < 3) begin req1_a = a1[i1]; req1_b = b1[i1]; end else req1_valid = 1'b0; end
      else     begin i0++; if (i0 < 3) begin req0_a = a0[i0]; req0_b = b0[i0]; end else req0_valid = 1'b0; end
      lat = 1;
      while (!(got ? resp1_valid : resp0_valid) && lat < 20) begin @(negedge clk); lat++; end
      gy = got ? resp1_y : resp0_y;
      gr = got ? resp1_rem : resp0_rem;
      checks++; if (lat !== 3 || gy !== ea / eb || gr !== ea % eb) begin errors++;
        $display("FAIL rr_result_%0d: lat=%0d y=%0d rem=%0d required 3/%0d/%0d", k, lat, gy, gr, ea / eb, ea % eb); end
      if (got) resp1_ready = 1'b1; else resp0_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_div_zero();
    test_backpressure();
    test_reset_abort();
    test_round_robin();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
